reg_desplazamiento_param: RTL

Parametrised multi-bit shift register with a sequential shifter. Shifts one bit position per clock for a programmed number of positions. Supports four shift modes and a start/busy/done handshake. Generalises the fixed 4-bit arithmetic-right shift register in the datapath to any width, a variable shift amount, left/right/rotate modes and a serial output tap.

---
 rtl/reg_desplazamiento_param.sv | 70 +++++++
 1 files changed

// File: rtl/reg_desplazamiento_param.sv
// reg_desplazamiento_param: width-parametrised sequential shifter, one bit per clock, four shift modes.
module reg_desplazamiento_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             start,
  input  logic [1:0]       Mode,
  input  logic [AMT_W-1:0] Amount,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Serial_Out,
  output logic             Busy,
  output logic             Done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [1:0]       mode;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;
  logic             fill;
  always_comb begin
    fill    = mode == 2'b01 ? Data_Out[WIDTH-1] : mode == 2'b11 ? Data_Out[0] : 1'b0;
    shifted = mode == 2'b10 ? {Data_Out[WIDTH-2:0], 1'b0} : {fill, Data_Out[WIDTH-1:1]};
    out_bit = mode == 2'b10 ? Data_Out[WIDTH-1] : Data_Out[0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      mode       <= 2'b00;
      count      <= '0;
      Data_Out   <= '0;
      Serial_Out <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            mode  <= Mode;
            count <= Amount;
            state <= Amount != '0 ? SHIFT : DONE;
            Busy  <= Amount != '0;
            Done  <= Amount == '0;
          end else if (load)
            Data_Out <= Data_In;
        SHIFT: begin
          Data_Out   <= shifted;
          Serial_Out <= out_bit;
          count      <= count - 1'b1;
          if (count == 1) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
endmodule
